// File: rtl/tank_game_pkg.sv
// Shared constants and FSM encoding for the tank game video path.
package tank_game_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] RED   = 3'b100;
  localparam logic [COLOUR_W-1:0] GREEN = 3'b010;
  localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DRAW = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_DRAW = ST_DRAW,
    S_DONE = ST_DONE
  } draw_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from ptr+1.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!any && req[(int'(ptr) + k) % NUM_REQ]) begin
        any = 1'b1;
        gnt[(int'(ptr) + k) % NUM_REQ] = 1'b1;
        idx = IW'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/vga_draw_arbiter.sv
// Shares the vga_adapter pixel port among sprite drawers: round-robin grant,
// one pixel per clock raster of a SIZE x SIZE square, clipped to the screen.
module vga_draw_arbiter
  import tank_game_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SIZE    = 4,
  parameter int X_W     = 8,
  parameter int Y_W     = 7
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*X_W-1:0]  req_x,
  input  logic [NUM_REQ*Y_W-1:0]  req_y,
  input  logic [NUM_REQ*3-1:0]    req_colour,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      done,
  output logic                    busy,
  output logic [X_W-1:0]          vga_x,
  output logic [Y_W-1:0]          vga_y,
  output logic [2:0]              vga_colour,
  output logic                    vga_plot
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] c;
  } op_t;

  draw_state_e        state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d, win_q, win_d;
  op_t                op_q, op_d, sel, src;
  logic [CW-1:0]      cx_q, cx_d, cy_q, cy_d, ecx, ecy;
  logic               fin_q, fin_d, emit;
  logic [NUM_REQ-1:0] grant_q, grant_d, done_q, done_d;
  logic               busy_q, busy_d, plot_q, plot_d;
  logic [X_W-1:0]     vx_q, vx_d;
  logic [Y_W-1:0]     vy_q, vy_d;
  logic [2:0]         vc_q, vc_d;
  logic [X_W:0]       sx;
  logic [Y_W:0]       sy;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    sel.x = req_x[arb_idx*X_W +: X_W];
    sel.y = req_y[arb_idx*Y_W +: Y_W];
    sel.c = req_colour[arb_idx*3 +: 3];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_d    = op_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    fin_d   = fin_q;
    grant_d = '0;
    done_d  = '0;
    plot_d  = 1'b0;
    vx_d    = vx_q;
    vy_d    = vy_q;
    vc_d    = vc_q;
    emit    = 1'b0;
    src     = op_q;
    ecx     = cx_q;
    ecy     = cy_q;
    sx      = '0;
    sy      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          state_d = S_DRAW;
          ptr_d   = arb_idx;
          win_d   = arb_idx;
          op_d    = sel;
          grant_d = arb_gnt;
          fin_d   = 1'b0;
          // pixel (0,0) goes out alongside grant, straight from the live operands
          emit    = 1'b1;
          src     = sel;
          ecx     = '0;
          ecy     = '0;
        end
      end
      S_DRAW: begin
        if (fin_q) state_d = S_DONE;
        else       emit    = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = NUM_REQ'(1) << win_q;
      end
      default: state_d = S_IDLE;
    endcase

    if (emit) begin
      sx     = {1'b0, src.x} + (X_W+1)'(ecx);
      sy     = {1'b0, src.y} + (Y_W+1)'(ecy);
      vx_d   = sx[X_W-1:0];
      vy_d   = sy[Y_W-1:0];
      vc_d   = src.c;
      // off-screen pixels still burn their cycle so sprite timing is fixed
      plot_d = (sx < (X_W+1)'(SCREEN_W)) && (sy < (Y_W+1)'(SCREEN_H));
      cx_d   = ecx + CW'(1);
      cy_d   = ecy;
      if (ecx == LAST) begin
        cx_d = '0;
        if (ecy == LAST) fin_d = 1'b1;
        else             cy_d  = ecy + CW'(1);
      end
    end
  end

  always_comb busy_d = (state_d != S_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      win_q   <= '0;
      op_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      fin_q   <= 1'b0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      plot_q  <= 1'b0;
      vx_q    <= '0;
      vy_q    <= '0;
      vc_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      fin_q   <= fin_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      plot_q  <= plot_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      vc_q    <= vc_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign vga_x      = vx_q;
  assign vga_y      = vy_q;
  assign vga_colour = vc_q;
  assign vga_plot   = plot_q;
endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Scoreboard bench: expected plotted pixels queued at stimulus, popped on vga_plot.
module tb_vga_draw_arbiter;
  localparam int N  = 4;
  localparam int SZ = 4;
  localparam int XW = 8;
  localparam int YW = 7;

  logic            clk = 1'b0;
  logic            resetn = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*XW-1:0] req_x = '0;
  logic [N*YW-1:0] req_y = '0;
  logic [N*3-1:0]  req_colour = '0;
  logic [N-1:0]    grant, done;
  logic            busy, vga_plot;
  logic [XW-1:0]   vga_x;
  logic [YW-1:0]   vga_y;
  logic [2:0]      vga_colour;

  vga_draw_arbiter #(.NUM_REQ(N), .SIZE(SZ), .X_W(XW), .Y_W(YW)) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y),
    .req_colour(req_colour), .grant(grant), .done(done), .busy(busy),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [2:0]    c;
  } pix_t;

  pix_t sb[$];
  int cyc = 0;
  int n_chk = 0, n_pass = 0;
  int plot_cnt = 0, g1_cnt = 0, gcnt = 0, dn_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%0h exp=%0h (cyc %0d)", tag, act, exp, cyc);
  endtask

  task automatic push_sprite(input int x, input int y, input logic [2:0] c);
    pix_t p;
    for (int yy = 0; yy < SZ; yy++)
      for (int xx = 0; xx < SZ; xx++)
        if (x + xx < 160 && y + yy < 120) begin
          p.x = XW'(x + xx);
          p.y = YW'(y + yy);
          p.c = c;
          sb.push_back(p);
        end
  endtask

  task automatic set_op(input int i, input int x, input int y, input logic [2:0] c);
    req_x[i*XW +: XW]    = XW'(x);
    req_y[i*YW +: YW]    = YW'(y);
    req_colour[i*3 +: 3] = c;
  endtask

  task automatic wait_ev(input bit is_done, input int lim, output int at, output logic [N-1:0] v);
    at = -1;
    v  = '0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (is_done ? (done != 0) : (grant != 0)) begin
        at = cyc;
        v  = is_done ? done : grant;
        break;
      end
    end
    if (at < 0) chk(is_done ? "timeout_done" : "timeout_grant", 32'(lim), 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req    = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", 32'({grant, done, busy, vga_plot}), 0);
    chk("rst_pix", 32'({vga_x, vga_y, vga_colour}), 0);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (vga_plot) begin
      plot_cnt++;
      if (sb.size() == 0) chk("extra_plot", 32'({vga_x, vga_y}), 32'(sb.size()));
      else chk("pix", 32'({vga_x, vga_y, vga_colour}), 32'(sb.pop_front()));
    end
    if (grant != 0) gcnt++;
    if (grant[1]) g1_cnt++;
    if (done != 0) dn_cnt++;
  end

  initial begin
    int c0, at, prev, d, g0;
    logic [N-1:0] v;
    #1;
    do_reset();

    // 1: single sprite, timing and raster order
    plot_cnt = 0;
    set_op(0, 10, 20, 3'b100);
    push_sprite(10, 20, 3'b100);
    c0 = cyc;
    req = 4'b0001;
    wait_ev(0, 10, at, v);
    chk("t1_grant", 32'(v), 32'b0001);
    chk("t1_grant_cyc", 32'(at), 32'(c0 + 1));
    chk("t1_busy_draw", 32'(busy), 1);
    req = '0;
    wait_ev(1, 40, at, v);
    chk("t1_done", 32'(v), 32'b0001);
    chk("t1_done_cyc", 32'(at), 32'(c0 + 18));
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_plots", 32'(plot_cnt), 16);
    chk("t1_hold_xy", 32'({vga_x, vga_y}), 32'({8'd13, 7'd23}));

    // 2: all requesting continuously, rotation and fixed spacing
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 20 * i + 5, 10 * i + 3, 3'(i + 1));
    for (int k = 0; k < 5; k++) push_sprite(20 * (k % N) + 5, 10 * (k % N) + 3, 3'((k % N) + 1));
    req = 4'b1111;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ev(0, 40, at, v);
      chk("t2_order", 32'(v), 32'(4'b0001 << (k % N)));
      if (k > 0) chk("t2_spacing", 32'(at - prev), 18);
      prev = at;
    end
    req = '0;
    wait_ev(1, 40, at, v);
    chk("t2_last_done", 32'(v), 32'b0001);

    // 3: bottom-right corner clipping
    @(negedge clk);
    plot_cnt = 0;
    set_op(0, 158, 118, 3'b111);
    push_sprite(158, 118, 3'b111);
    c0 = cyc;
    req = 4'b0001;
    wait_ev(0, 10, at, v);
    req = '0;
    wait_ev(1, 40, at, v);
    chk("t3_done_cyc", 32'(at), 32'(c0 + 18));
    chk("t3_plots", 32'(plot_cnt), 4);
    chk("t3_trunc_xy", 32'({vga_x, vga_y}), 32'({8'd161, 7'd121}));
    chk("t3_plot_low", 32'(vga_plot), 0);

    // 4: request arriving mid-draw waits for DONE
    @(negedge clk);
    set_op(0, 40, 50, 3'b010);
    push_sprite(40, 50, 3'b010);
    req = 4'b0001;
    wait_ev(0, 10, at, v);
    req = '0;
    repeat (5) @(negedge clk);
    set_op(2, 60, 70, 3'b100);
    push_sprite(60, 70, 3'b100);
    req[2] = 1'b1;
    g0 = gcnt;
    wait_ev(1, 40, d, v);
    chk("t4_done0", 32'(v), 32'b0001);
    chk("t4_no_early_grant", 32'(gcnt), 32'(g0));
    wait_ev(0, 10, at, v);
    chk("t4_grant2", 32'(v), 32'b0100);
    chk("t4_grant2_cyc", 32'(at), 32'(d + 1));
    req = '0;
    wait_ev(1, 40, at, v);
    chk("t4_done2", 32'(v), 32'b0100);

    // 5: reset on the 7th pixel
    @(negedge clk);
    plot_cnt = 0;
    set_op(0, 30, 30, 3'b111);
    push_sprite(30, 30, 3'b111);
    req = 4'b0001;
    wait_ev(0, 10, at, v);
    req = '0;
    repeat (6) @(negedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("t5_async_clear", 32'({grant, done, busy, vga_plot}), 0);
    chk("t5_plots_before", 32'(plot_cnt), 7);
    sb.delete();
    d = dn_cnt;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_no_done", 32'(dn_cnt), 32'(d));
    set_op(0, 0, 0, 3'b001);
    set_op(3, 100, 60, 3'b110);
    push_sprite(0, 0, 3'b001);
    push_sprite(100, 60, 3'b110);
    c0 = cyc;
    req = 4'b1001;
    wait_ev(0, 10, at, v);
    chk("t5_ptr_reset", 32'(v), 32'b0001);
    chk("t5_grant_cyc", 32'(at), 32'(c0 + 1));
    req[0] = 1'b0;
    wait_ev(0, 40, at, v);
    chk("t5_grant3", 32'(v), 32'b1000);
    req[3] = 1'b0;
    wait_ev(1, 40, at, v);
    chk("t5_done3", 32'(v), 32'b1000);

    // 6: withdrawn pulse on requester 1
    @(negedge clk);
    g1_cnt = 0;
    set_op(0, 80, 30, 3'b000);
    push_sprite(80, 30, 3'b000);
    req = 4'b0001;
    wait_ev(0, 10, at, v);
    req = '0;
    repeat (4) @(negedge clk);
    set_op(1, 90, 90, 3'b111);
    req[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    wait_ev(1, 40, at, v);
    repeat (25) @(negedge clk);
    chk("t6_no_grant1", 32'(g1_cnt), 0);
    chk("t6_idle", 32'(busy), 0);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
